// File: rtl/riscv_defs.sv
// Shared definitions for the multicycle RISC-V control path.
package riscv_defs;

    // Fixed state encoding; 011 and 110 are illegal.
    typedef enum logic [2:0] {
        EST_IF   = 3'b000,
        EST_ID   = 3'b001,
        EST_EX   = 3'b010,
        EST_MEM  = 3'b100,
        EST_WB   = 3'b101,
        EST_HALT = 3'b111
    } estado_t;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_CMP   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    localparam logic [2:0] F3_BEQ = 3'b000;
    localparam logic [2:0] F3_BNE = 3'b001;

    function automatic logic op_suportado(input logic [6:0] op);
        return op inside {OP_R, OP_I, OP_LOAD, OP_STORE, OP_BRANCH};
    endfunction

endpackage

// File: rtl/decod_controle.sv
// Combinational decode of state and latched instruction fields into datapath strobes.
module decod_controle
    import riscv_defs::*;
(
    input  logic [2:0] i_estado,
    input  logic [6:0] i_op,
    input  logic [2:0] i_f3,
    input  logic       i_zero,
    output logic       o_memread,
    output logic       o_memwrite,
    output logic       o_regwrite,
    output logic       o_pcwrite,
    output logic       o_pcbranch,
    output logic       o_alusrc,
    output logic       o_memtoreg,
    output logic [1:0] o_aluop
);

    logic w_load;
    logic w_store;
    logic w_branch;
    logic w_arit;
    logic w_vivo;
    logic w_cond;

    assign w_load   = (i_op == OP_LOAD);
    assign w_store  = (i_op == OP_STORE);
    assign w_branch = (i_op == OP_BRANCH);
    assign w_arit   = (i_op == OP_R) || (i_op == OP_I);
    // HALT and the two illegal codes silence every strobe.
    assign w_vivo   = i_estado inside {EST_IF, EST_ID, EST_EX, EST_MEM, EST_WB};
    assign w_cond   = ((i_f3 == F3_BEQ) && i_zero) || ((i_f3 == F3_BNE) && !i_zero);

    // Strobe decode, all defaults low.
    always_comb begin
        o_memread  = 1'b0;
        o_memwrite = 1'b0;
        o_regwrite = 1'b0;
        o_pcwrite  = 1'b0;
        o_pcbranch = 1'b0;
        o_alusrc   = 1'b0;
        o_memtoreg = 1'b0;
        o_aluop    = ALUOP_ADD;
        if (w_vivo) begin
            o_pcwrite  = (i_estado == EST_IF);
            o_memread  = (i_estado == EST_MEM) && w_load;
            o_memwrite = (i_estado == EST_MEM) && w_store;
            o_regwrite = (i_estado == EST_WB);
            o_memtoreg = w_load;
            o_alusrc   = w_load || w_store || (i_op == OP_I);
            o_pcbranch = (i_estado == EST_EX) && w_branch && w_cond;
            if (w_branch) begin
                o_aluop = ALUOP_CMP;
            end else if (w_arit) begin
                o_aluop = ALUOP_FUNCT;
            end
        end
    end

endmodule

// File: rtl/unidade_controle.sv
// Multicycle control FSM with cycle and retired-instruction counters.
module unidade_controle
    import riscv_defs::*;
#(
    parameter int unsigned LARG_CONT = 32,
    parameter logic [6:0]  OP_HALT   = 7'b0000000
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [6:0]           opcode,
    input  logic [2:0]           funct3,
    input  logic                 zero,
    output logic [2:0]           estado,
    output logic                 memread,
    output logic                 memwrite,
    output logic                 regwrite,
    output logic                 pcwrite,
    output logic                 pcbranch,
    output logic                 alusrc,
    output logic                 memtoreg,
    output logic [1:0]           aluop,
    output logic                 halt,
    output logic [LARG_CONT-1:0] ciclos,
    output logic [LARG_CONT-1:0] instrucoes
);

    estado_t              r_estado;
    estado_t              w_prox;
    logic [6:0]           r_op;
    logic [2:0]           r_f3;
    logic [LARG_CONT-1:0] r_ciclos;
    logic [LARG_CONT-1:0] r_instr;
    logic                 w_retira;

    // Next-state selection; anything unexpected parks the machine in HALT.
    always_comb begin
        w_prox = EST_HALT;
        case (r_estado)
            EST_IF: w_prox = EST_ID;
            EST_ID: begin
                if ((opcode == OP_HALT) || !op_suportado(opcode)) begin
                    w_prox = EST_HALT;
                end else begin
                    w_prox = EST_EX;
                end
            end
            EST_EX: begin
                case (r_op)
                    OP_R, OP_I:         w_prox = EST_WB;
                    OP_LOAD, OP_STORE:  w_prox = EST_MEM;
                    OP_BRANCH:          w_prox = EST_IF;
                    default:            w_prox = EST_HALT;
                endcase
            end
            EST_MEM: begin
                if (r_op == OP_LOAD) begin
                    w_prox = EST_WB;
                end else if (r_op == OP_STORE) begin
                    w_prox = EST_IF;
                end else begin
                    w_prox = EST_HALT;
                end
            end
            EST_WB:   w_prox = EST_IF;
            default:  w_prox = EST_HALT;
        endcase
    end

    // An instruction retires on the edge leaving its final state.
    assign w_retira = (r_estado == EST_WB) ||
                      ((r_estado == EST_MEM) && (r_op == OP_STORE)) ||
                      ((r_estado == EST_EX) && (r_op == OP_BRANCH));

    // State, latched instruction fields and counters with synchronous reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_estado <= EST_IF;
            r_op     <= '0;
            r_f3     <= '0;
            r_ciclos <= '0;
            r_instr  <= '0;
        end else begin
            r_estado <= w_prox;
            if (r_estado == EST_ID) begin
                r_op <= opcode;
                r_f3 <= funct3;
            end
            if (r_estado != EST_HALT) begin
                r_ciclos <= r_ciclos + LARG_CONT'(1);
                if (w_retira) begin
                    r_instr <= r_instr + LARG_CONT'(1);
                end
            end
        end
    end

    decod_controle u_decod (
        .i_estado   (r_estado),
        .i_op       (r_op),
        .i_f3       (r_f3),
        .i_zero     (zero),
        .o_memread  (memread),
        .o_memwrite (memwrite),
        .o_regwrite (regwrite),
        .o_pcwrite  (pcwrite),
        .o_pcbranch (pcbranch),
        .o_alusrc   (alusrc),
        .o_memtoreg (memtoreg),
        .o_aluop    (aluop)
    );

    assign estado     = r_estado;
    assign halt       = (r_estado == EST_HALT);
    assign ciclos     = r_ciclos;
    assign instrucoes = r_instr;

endmodule

// File: tb/tb_unidade_controle.sv
// Scoreboard bench: driver updates a sequence-list model and queues expectations,
// monitor pops and compares one entry per cycle.
module tb_unidade_controle;

    localparam int W = 6;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic [6:0]   opcode = '0;
    logic [2:0]   funct3 = '0;
    logic         zero = 1'b0;
    logic [2:0]   estado;
    logic         memread, memwrite, regwrite, pcwrite, pcbranch, alusrc, memtoreg, halt;
    logic [1:0]   aluop;
    logic [W-1:0] ciclos, instrucoes;

    always #5 clk = ~clk;

    unidade_controle #(
        .LARG_CONT (W),
        .OP_HALT   (7'b0000000)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .opcode     (opcode),
        .funct3     (funct3),
        .zero       (zero),
        .estado     (estado),
        .memread    (memread),
        .memwrite   (memwrite),
        .regwrite   (regwrite),
        .pcwrite    (pcwrite),
        .pcbranch   (pcbranch),
        .alusrc     (alusrc),
        .memtoreg   (memtoreg),
        .aluop      (aluop),
        .halt       (halt),
        .ciclos     (ciclos),
        .instrucoes (instrucoes)
    );

    // strobes = {memread, memwrite, regwrite, pcwrite, pcbranch, alusrc, memtoreg, aluop, halt}
    typedef struct packed {
        logic [2:0]   estado;
        logic [9:0]   strobes;
        logic [W-1:0] ciclos;
        logic [W-1:0] instr;
    } saida_t;

    saida_t fila[$];
    int     total = 0;
    int     bad = 0;
    int     ciclo_mon = 0;

    // Model: current state code plus the list of states still to visit for this instruction.
    logic [2:0]   m_est = 3'd0;
    logic [2:0]   m_pend[$];
    logic [6:0]   m_op = '0;
    logic [2:0]   m_f3 = '0;
    logic [W-1:0] m_cyc = '0;
    logic [W-1:0] m_ins = '0;

    function automatic saida_t esperado(input logic z);
        saida_t s;
        logic ld, st, br, ii, ar, vivo, tomado;
        logic [1:0] aop;
        ld   = (m_op == 7'b0000011);
        st   = (m_op == 7'b0100011);
        br   = (m_op == 7'b1100011);
        ii   = (m_op == 7'b0010011);
        ar   = (m_op == 7'b0110011) || ii;
        vivo = m_est inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5};
        tomado = br && (((m_f3 == 3'd0) && z) || ((m_f3 == 3'd1) && !z));
        aop  = br ? 2'b01 : (ar ? 2'b10 : 2'b00);
        s.estado = m_est;
        s.ciclos = m_cyc;
        s.instr  = m_ins;
        if (vivo) begin
            s.strobes = {(m_est == 3'd4) && ld, (m_est == 3'd4) && st, (m_est == 3'd5),
                         (m_est == 3'd0), (m_est == 3'd2) && tomado, ld || st || ii, ld,
                         aop, 1'b0};
        end else begin
            s.strobes = {9'b0, (m_est == 3'd7)};
        end
        return s;
    endfunction

    task automatic passo(input logic rst, input logic [6:0] op, input logic [2:0] f3,
                         input logic z);
        @(negedge clk);
        rst_n  = rst;
        opcode = op;
        funct3 = f3;
        zero   = z;
        @(posedge clk);
        if (!rst) begin
            m_est = 3'd0;
            m_pend.delete();
            m_op  = '0;
            m_f3  = '0;
            m_cyc = '0;
            m_ins = '0;
        end else if (m_est != 3'd7) begin
            m_cyc = m_cyc + 1'b1;
            if (m_est == 3'd0) begin
                m_est = 3'd1;
            end else if (m_est == 3'd1) begin
                m_op = op;
                m_f3 = f3;
                case (op)
                    7'b0110011, 7'b0010011: m_pend = {3'd2, 3'd5};
                    7'b0000011:             m_pend = {3'd2, 3'd4, 3'd5};
                    7'b0100011:             m_pend = {3'd2, 3'd4};
                    7'b1100011:             m_pend = {3'd2};
                    default:                m_pend.delete();
                endcase
                if (m_pend.size() == 0) m_est = 3'd7;
                else m_est = m_pend.pop_front();
            end else if (m_pend.size() == 0) begin
                m_est = 3'd0;
                m_ins = m_ins + 1'b1;
            end else begin
                m_est = m_pend.pop_front();
            end
        end
        fila.push_back(esperado(z));
    endtask

    task automatic instr(input logic [6:0] op, input logic [2:0] f3, input logic z,
                         input int n);
        for (int k = 0; k < n; k++) passo(1'b1, op, f3, z);
    endtask

    // Monitor: compare DUT outputs against the queued expectation each cycle.
    initial begin
        saida_t e, a;
        forever begin
            @(posedge clk);
            #1;
            if (fila.size() > 0) begin
                e = fila.pop_front();
                a.estado  = estado;
                a.strobes = {memread, memwrite, regwrite, pcwrite, pcbranch, alusrc, memtoreg,
                             aluop, halt};
                a.ciclos  = ciclos;
                a.instr   = instrucoes;
                ciclo_mon++;
                total++;
                if (a.estado !== e.estado) begin
                    bad++;
                    $display("FAIL estado cyc=%0d got=%b exp=%b", ciclo_mon, a.estado, e.estado);
                end
                total++;
                if (a.strobes !== e.strobes) begin
                    bad++;
                    $display("FAIL strobes cyc=%0d estado=%b got=%b exp=%b", ciclo_mon,
                             e.estado, a.strobes, e.strobes);
                end
                total++;
                if ({a.ciclos, a.instr} !== {e.ciclos, e.instr}) begin
                    bad++;
                    $display("FAIL contadores cyc=%0d got=%0d/%0d exp=%0d/%0d", ciclo_mon,
                             a.ciclos, a.instr, e.ciclos, e.instr);
                end
            end
        end
    end

    // Driver: directed scenarios, then randomized traffic.
    initial begin
        int parado;
        logic [6:0] op;
        int sel;
        passo(1'b0, 7'b0110011, 3'd0, 1'b0);
        passo(1'b0, 7'b0110011, 3'd0, 1'b0);
        instr(7'b0110011, 3'd0, 1'b0, 4);   // R-type
        instr(7'b0000011, 3'd2, 1'b0, 5);   // load
        instr(7'b0100011, 3'd2, 1'b1, 4);   // store
        instr(7'b1100011, 3'd0, 1'b1, 3);   // beq taken
        instr(7'b1100011, 3'd1, 1'b1, 3);   // bne not taken
        instr(7'b0010011, 3'd0, 1'b0, 4);   // I-type
        instr(7'b0000000, 3'd0, 1'b0, 2);   // halt opcode
        instr(7'b0000000, 3'd0, 1'b1, 10);  // frozen
        passo(1'b0, 7'b0, 3'd0, 1'b0);
        instr(7'b0100011, 3'd0, 1'b0, 3);   // into MEM of a store
        passo(1'b0, 7'b0100011, 3'd0, 1'b0);
        instr(7'b1111111, 3'd0, 1'b0, 4);   // illegal opcode
        passo(1'b0, 7'b0, 3'd0, 1'b0);

        parado = 0;
        for (int c = 0; c < 2000; c++) begin
            sel = $urandom_range(0, 39);
            if (sel < 8)       op = 7'b0110011;
            else if (sel < 14) op = 7'b0010011;
            else if (sel < 21) op = 7'b0000011;
            else if (sel < 28) op = 7'b0100011;
            else if (sel < 37) op = 7'b1100011;
            else if (sel < 38) op = 7'b0000000;
            else               op = 7'($urandom);
            parado = (m_est == 3'd7) ? parado + 1 : 0;
            passo((parado <= 12) && ($urandom_range(0, 299) != 0), op,
                  3'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
        end

        repeat (2) @(posedge clk);
        #3;
        total++;
        if (fila.size() != 0) begin
            bad++;
            $display("FAIL fila_vazia got=%0d exp=0", fila.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/unidade_controle.md
Name: unidade_controle

Overview:
- Multicycle control FSM for the RISC-V datapath.
- Generates the 3-bit `estado` bus that the data memory, register file, ALU and PC stages qualify on.
- Generates per-state strobes: memread, memwrite, regwrite, PC write, branch.
- Decodes opcode/funct3 latched from the instruction register and counts cycles and retired instructions for the testbench dump.

Parameters:
- LARG_CONT, 32, width of the cycle and instruction counters.
- OP_HALT, 7'b0000000, opcode that stops the machine.

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  synchronous active-low reset
- opcode  in  7  instruction[6:0] from the instruction register
- funct3  in  3  instruction[14:12]
- zero  in  1  ALU zero flag, valid in EX
- estado  out  3  current state, registered
- memread  out  1  data memory read strobe
- memwrite  out  1  data memory write strobe
- regwrite  out  1  register file write enable
- pcwrite  out  1  PC <= PC+4
- pcbranch  out  1  PC <= branch target
- alusrc  out  1  0 = rs2, 1 = immediate
- memtoreg  out  1  0 = ALU result, 1 = memory data
- aluop  out  2  00 add, 01 sub/compare, 10 funct-decoded
- halt  out  1  sticky stop indicator
- ciclos  out  LARG_CONT  cycles since reset
- instrucoes  out  LARG_CONT  retired instructions

Behaviour:
- **Reset.** While rst_n=0 at a clk edge: estado=000; halt=0; ciclos=0; instrucoes=0; latched op/funct3 cleared to 0. Reset mid-instruction aborts it and no strobe is asserted afterwards.
- **Encoding.** Fixed: 000 IF, 001 ID, 010 EX, 100 MEM, 101 WB, 111 HALT. Codes 011 and 110 are illegal and go to HALT on the next edge.
- **Transitions**, one per clk edge:
  - IF -> ID.
  - ID -> EX; latches opcode and funct3 into internal op_r/f3_r at this edge. If opcode is OP_HALT or unsupported, ID -> HALT instead.
  - EX -> WB for R-type 0110011 and I-type 0010011.
  - EX -> MEM for load 0000011 and store 0100011.
  - EX -> IF for branch 1100011.
  - MEM -> WB for load; MEM -> IF for store.
  - WB -> IF.
  - HALT -> HALT until reset.
- **Latency** in cycles: R/I 4, load 5, store 4, branch 3.
- **Strobes** are combinational from estado and op_r only. They are stable for the whole state, so consumers sample at the closing edge.
  - pcwrite = (estado==IF).
  - memread = (estado==MEM) & load.
  - memwrite = (estado==MEM) & store.
  - regwrite = (estado==WB).
  - memtoreg = load.
  - alusrc = load | store | I-type.
  - aluop = 01 for branch, 10 for R/I, 00 otherwise.
  - pcbranch = (estado==EX) & branch & cond, where cond = zero for funct3 000 (beq) and !zero for funct3 001 (bne). Other branch funct3 values: not taken.
  - All strobes are 0 in HALT and in illegal states.
  - The PC adder is expected to produce PC+4 in IF; pcbranch overrides the PC in EX.
- **halt** = (estado==HALT).
- **Counters.**
  - ciclos increments every non-reset cycle while not in HALT.
  - instrucoes increments on the edge leaving the last state of an instruction: WB, store MEM, or branch EX.
  - Both wrap modulo 2^LARG_CONT.
  - Both freeze in HALT.

Decomposition:
- Shared package `riscv_defs` holds:
  - state constants EST_IF, EST_ID, EST_EX, EST_MEM, EST_WB, EST_HALT;
  - opcode constants OP_R, OP_I, OP_LOAD, OP_STORE, OP_BRANCH;
  - aluop encodings.
- One natural sub-module, `decod_controle`: purely combinational decode of op_r/f3_r/estado/zero into the strobe set. The FSM and counters stay in unidade_controle.

Test Plan:
- **Reset and R-type.** Reset for 2 cycles, release, R-type opcode 0110011 -> estado 000,001,010,101,000. regwrite=1 only in 101. instrucoes=1 and ciclos=4 after the 4th edge.
- **Load.** opcode 0000011 -> 5-cycle sequence through 100. memread=1 and memtoreg=1 in 100, memwrite=0 throughout, regwrite=1 in 101.
- **Store.** opcode 0100011 -> 000,001,010,100,000. memwrite=1 only in 100, regwrite never asserted.
- **Branches.**
  - beq (f3 000) with zero=1 in EX -> pcbranch=1 for exactly one cycle, return to 000 after 3 cycles.
  - bne (f3 001) with zero=1 -> pcbranch=0.
- **Halt.** opcode 0000000 at ID -> estado 111 and halt=1 with all strobes 0. Counters frozen for 10 cycles. rst_n=0 for one edge -> estado 000 and counters 0.
- **Reset mid-instruction.** Reset asserted while in MEM on a store -> memwrite drops after that edge and estado=000. Illegal opcode 1111111 -> HALT from ID.
